// File: rtl/ram16x1_scan_reader.sv
// ram16x1_scan_reader: read-side controller for the 16x1 single-bit RAM.
// It walks addresses 0..DEPTH-1, samples the RAM's asynchronous read data at
// each address and packs the bits into one parallel word. The word is then
// offered on a valid/ready handshake. Each address can be given SETTLE_CYC
// idle cycles before its sample is taken.
// Optional feature: define RDR_PARITY_EN to add a registered parity output
// (XOR of all word bits), updated together with valid.
module ram16x1_scan_reader #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int SETTLE_CYC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ram_q,
    output logic [AW-1:0]    ram_a,
`ifdef RDR_PARITY_EN
    output logic             parity,
`endif
    output logic             busy,
    output logic             valid,
    input  logic             ready,
    output logic [DEPTH-1:0] word
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;

    // Index of the final settle cycle. It is not used when SETTLE_CYC is 0,
    // because SETTLE is bypassed in that case.
    localparam logic [2:0]    SETTLE_LAST = 3'(SETTLE_CYC > 0 ? SETTLE_CYC - 1 : 0);
    localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);
    // State entered after each address change. With no settle time the
    // sample is taken on the very next edge.
    localparam state_t        FIRST_STEP  = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;

    state_t           state_reg, state_next;
    logic [AW-1:0]    addr_reg, addr_next;
    logic             busy_reg, busy_next;
    logic             valid_reg, valid_next;
    logic [2:0]       settle_reg, settle_next;
    logic [DEPTH-1:0] word_reg, word_next;

    // Each word bit updates only in SAMPLE while its own address is on the
    // bus. At all other times ram_q is ignored.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
            assign word_next[gi] = (state_reg == SAMPLE && addr_reg == AW'(gi)) ? ram_q
                                                                                : word_reg[gi];
        end
    endgenerate

    // Next-state and control logic for the scan sequencer.
    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        busy_next   = busy_reg;
        valid_next  = valid_reg;
        settle_next = settle_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = FIRST_STEP;
                    addr_next   = '0;
                    busy_next   = 1'b1;
                    settle_next = '0;
                end
            end
            SETTLE: begin
                if (settle_reg == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end else begin
                    settle_next = settle_reg + 3'd1;
                end
            end
            SAMPLE: begin
                if (addr_reg == LAST_ADDR) begin
                    state_next = HOLD;
                    valid_next = 1'b1;
                end else begin
                    addr_next   = addr_reg + AW'(1);
                    settle_next = '0;
                    state_next  = FIRST_STEP;
                end
            end
            HOLD: begin
                if (ready) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                    addr_next  = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers. Reset takes effect immediately and
    // discards any partially scanned word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            busy_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            settle_reg <= '0;
            word_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            busy_reg   <= busy_next;
            valid_reg  <= valid_next;
            settle_reg <= settle_next;
            word_reg   <= word_next;
        end
    end

`ifdef RDR_PARITY_EN
    logic parity_reg;
    logic parity_next;

    // Parity is computed from the completed word on the same edge that
    // raises valid. It then stays frozen with the word.
    always_comb begin
        parity_next = parity_reg;
        if (state_reg == SAMPLE && addr_reg == LAST_ADDR) begin
            parity_next = ^word_next;
        end
    end

    // Parity register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= parity_next;
        end
    end

    assign parity = parity_reg;
`endif

    assign ram_a = addr_reg;
    assign busy  = busy_reg;
    assign valid = valid_reg;
    assign word  = word_reg;

endmodule

// File: tb/tb_ram16x1_scan_reader.sv
// Testbench for ram16x1_scan_reader. Two readers run side by side: one with
// no settle time and one with a settle time of 2 cycles. They share one
// behavioural 16x1 RAM. Every cycle, each reader is compared against a
// reference model that computes the expected outputs from the scan timing
// rules. Directed literal checks pin the model's expected values.
module tb_ram16x1_scan_reader;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst, start, ready;
    logic we;
    logic [3:0] wa;
    logic wd;
    logic [15:0] mem;

    always #5 clk = ~clk;

    // 16x1 RAM with a clocked write port and asynchronous reads.
    always @(posedge clk) if (we) mem[wa] <= wd;

    logic [3:0]  ram_a_w [2];
    logic        busy_w  [2];
    logic        valid_w [2];
    logic [15:0] word_w  [2];
    logic        ram_q_w [2];
    bit          glitch  [2];
`ifdef RDR_PARITY_EN
    logic        parity_w [2];
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            assign ram_q_w[gi] = mem[ram_a_w[gi]] ^ glitch[gi];
            ram16x1_scan_reader #(.DEPTH(16), .AW(4), .SETTLE_CYC(gi * 2)) dut (
`ifdef RDR_PARITY_EN
                .parity(parity_w[gi]),
`endif
                .clk(clk), .rst(rst), .start(start), .ram_q(ram_q_w[gi]),
                .ram_a(ram_a_w[gi]), .busy(busy_w[gi]), .valid(valid_w[gi]),
                .ready(ready), .word(word_w[gi]));
        end
    endgenerate

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, d, $time, act, exp);
        end
    endtask

    // Reference model: edges elapsed since start (m_j) determine the expected outputs.
    int          P [2] = '{1, 3};
    int          m_j [2];
    int          m_addr [2];
    bit          m_busy [2];
    bit          m_valid [2];
    bit          m_parity [2];
    logic [15:0] m_word [2];

    task automatic model_step(input int d);
        int k;
        if (rst) begin
            m_busy[d] = 0; m_valid[d] = 0; m_word[d] = '0; m_addr[d] = 0; m_parity[d] = 0; m_j[d] = 0;
        end else if (!m_busy[d]) begin
            if (start) begin
                m_busy[d] = 1; m_j[d] = 0; m_addr[d] = 0;
            end
        end else if (m_valid[d]) begin
            if (ready) begin
                m_valid[d] = 0; m_busy[d] = 0; m_addr[d] = 0;
            end
        end else begin
            m_j[d]++;
            if (m_j[d] % P[d] == 0) begin
                k = m_j[d] / P[d] - 1;
                m_word[d][k] = mem[k];
                if (k == DEPTH - 1) begin
                    m_valid[d] = 1;
                    m_parity[d] = ^m_word[d];
                end
            end
            m_addr[d] = (m_j[d] / P[d] > DEPTH - 1) ? DEPTH - 1 : m_j[d] / P[d];
        end
    endtask

    // Advance the model on each edge, then compare every output just after the edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) model_step(d);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("busy", d, busy_w[d], m_busy[d]);
            chk("valid", d, valid_w[d], m_valid[d]);
            chk("ram_a", d, ram_a_w[d], m_addr[d]);
            chk("word", d, word_w[d], m_word[d]);
`ifdef RDR_PARITY_EN
            chk("parity", d, parity_w[d], m_parity[d]);
`endif
        end
    end

    // Corrupt ram_q at random, but never in a cycle whose next edge is a capture.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++)
            glitch[d] = ($urandom_range(0, 1) == 1) &&
                        !(m_busy[d] && !m_valid[d] && ((m_j[d] + 1) % P[d] == 0));
    end

    task automatic write_word(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            we = 1'b1; wa = 4'(i); wd = v[i];
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_w[0] || busy_w[1]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", 0, 32'(busy_w[0] | busy_w[1]), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int v0, v1, b17, vv17, a2, a3, n;
        logic [15:0] w0, w1, r;
        rst = 1'b1; start = 1'b0; ready = 1'b0; we = 1'b0; wa = '0; wd = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", d, busy_w[d], 0);
            chk("reset_valid", d, valid_w[d], 0);
            chk("reset_word", d, word_w[d], 0);
            chk("reset_ram_a", d, ram_a_w[d], 0);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Nominal scan timing for both settle settings.
        ready = 1'b1;
        write_word(16'hA5C3);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        v0 = -1; v1 = -1; b17 = -1; vv17 = -1; a2 = -1; a3 = -1; w0 = '0; w1 = '0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #2;
            if (valid_w[0] && v0 < 0) begin v0 = e; w0 = word_w[0]; end
            if (valid_w[1] && v1 < 0) begin v1 = e; w1 = word_w[1]; end
            if (e == 17) begin b17 = busy_w[0]; vv17 = valid_w[0]; end
            if (e == 2) a2 = ram_a_w[1];
            if (e == 3) a3 = ram_a_w[1];
        end
        chk("valid_edge_s0", 0, v0, 16);
        chk("word_s0", 0, w0, 16'hA5C3);
        chk("busy_e17_s0", 0, b17, 0);
        chk("valid_e17_s0", 0, vv17, 0);
        chk("valid_edge_s2", 1, v1, 48);
        chk("word_s2", 1, w1, 16'hA5C3);
        chk("ram_a_e2_s2", 1, a2, 0);
        chk("ram_a_e3_s2", 1, a3, 1);

        // Hold with ready low and start pulsed; then handshake with start high.
        wait_idle();
        ready = 1'b0;
        pulse_start();
        n = 0;
        while (!(valid_w[0] && valid_w[1]) && n < 200) begin @(negedge clk); n++; end
        chk("hold_reached", 0, 32'(valid_w[0] & valid_w[1]), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); start = 1'b1;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("hold_ram_a", d, ram_a_w[d], 15);
            chk("hold_word", d, word_w[d], 16'hA5C3);
            chk("hold_busy", d, busy_w[d], 1);
        end
        ready = 1'b1;
        @(posedge clk); #2;
        chk("handshake_busy", 0, busy_w[0], 0);
        chk("handshake_start_ignored", 1, busy_w[1], 0);
        @(posedge clk); #2;
        chk("restart_next_cycle", 0, busy_w[0], 1);
        start = 1'b0;
        wait_idle();

        // Reset in the middle of a scan.
        r = 16'($urandom);
        write_word(r);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("midrst_busy", d, busy_w[d], 0);
            chk("midrst_valid", d, valid_w[d], 0);
            chk("midrst_word", d, word_w[d], 0);
            chk("midrst_ram_a", d, ram_a_w[d], 0);
        end
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        pulse_start();
        wait_idle();
        chk("after_rst_word", 0, word_w[0], r);
        chk("after_rst_word", 1, word_w[1], r);

        // Back-to-back scans with a RAM rewrite between them.
        write_word(16'hFFFF);
        pulse_start();
        wait_idle();
        chk("b2b_first", 0, word_w[0], 16'hFFFF);
        write_word(16'h0000);
        pulse_start();
        wait_idle();
        chk("b2b_second", 0, word_w[0], 16'h0000);
        chk("b2b_second", 1, word_w[1], 16'h0000);

        // Randomised traffic: random contents, start/ready, and occasional resets.
        for (int it = 0; it < 20; it++) begin
            ready = 1'b1;
            wait_idle();
            write_word(16'($urandom));
            for (int c = 0; c < 120; c++) begin
                @(negedge clk);
                start = ($urandom_range(0, 7) == 0);
                ready = ($urandom_range(0, 2) != 0);
                rst   = ($urandom_range(0, 149) == 0);
            end
            @(negedge clk);
            start = 1'b0; rst = 1'b0; ready = 1'b1;
        end
        wait_idle();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
